// File: rtl/key_encode_latch_pkg.sv
// Shared types and helpers for the key encoder/latch block.
package key_encode_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_e;

  function automatic int kel_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/key_encode_latch_if.sv
// Key bus in, latched code / strobe / status / segment pattern out.
interface key_encode_latch_if #(
  parameter int N_KEYS = 8,
  parameter int CODE_W = 4
);
  logic [N_KEYS-1:0] din;
  logic              clr;
  logic [CODE_W-1:0] value;
  logic              valid;
  logic              held;
  logic              err;
  logic [6:0]        dout_digit;

  modport master (output din, clr, input value, valid, held, err, dout_digit);
  modport slave  (input din, clr, output value, valid, held, err, dout_digit);
endinterface

// File: rtl/key_encode_latch_sevenseg.sv
// Hex digit to seven-segment pattern, active high, bit order {g,f,e,d,c,b,a}.
module SevenSeg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h00;
    case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      default: seg_o = 7'h71;
    endcase
  end
endmodule

// File: rtl/key_encode_latch_sync.sv
// Two-flop synchroniser for the asynchronous key bus.
module key_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/key_encode_latch.sv
// Synchronise, encode and debounce a key bus; latch the code, strobe, flag multi-key input.
module key_encode_latch
  import key_encode_latch_pkg::*;
#(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MODE            = 0
) (
  input logic              clk,
  input logic              rst_n,
  key_encode_latch_if.slave bus
);
  localparam int CODE_W = kel_clog2(N_KEYS + 1);
  localparam int CNT_W  = kel_clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sdin;
  logic [CODE_W-1:0] cand;
  logic              multi;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] cand_reg_q, value_q;
  logic              valid_q, held_q, err_q;

  key_sync #(.W(N_KEYS)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(bus.din), .q_o(sdin));

  // Ascending scan: the highest-index set bit (lowest code) is the last write.
  always_comb begin
    cand  = '0;
    multi = 1'b0;
    for (int i = 0; i < N_KEYS; i++)
      if (sdin[i]) cand = CODE_W'(N_KEYS - i);
    if (MODE == 0 && (sdin & (sdin - N_KEYS'(1))) != '0) begin
      cand  = '0;
      multi = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_reg_q <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (multi)        err_q <= 1'b1;
      else if (bus.clr) err_q <= 1'b0;
      // A latch in the same cycle overrides this below.
      if (bus.clr) value_q <= '0;
      case (state_q)
        IDLE: if (cand != '0) begin
          cand_reg_q <= cand;
          cnt_q      <= CNT_W'(1);
          state_q    <= COUNT;
        end
        COUNT: begin
          if (cand == cand_reg_q) begin
            if (cnt_q == CNT_MAX) begin
              value_q <= cand_reg_q;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cand != '0) begin
            cand_reg_q <= cand;
            cnt_q      <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        HELD: begin
          if (sdin != '0) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.held  = held_q;
  assign bus.err   = err_q;

  SevenSeg u_seg (.hex_i(4'(value_q)), .seg_o(bus.dout_digit));
endmodule

// File: tb/tb_key_encode_latch.sv
// Scoreboard bench: three configurations (strict, priority, 12-key/2-cycle debounce).
module tb_key_encode_latch;
  typedef struct {
    int code;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din8;
  logic [11:0] din12;
  logic        clr;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_encode_latch_if #(.N_KEYS(8),  .CODE_W(4)) if0 ();
  key_encode_latch_if #(.N_KEYS(8),  .CODE_W(4)) if1 ();
  key_encode_latch_if #(.N_KEYS(12), .CODE_W(4)) if2 ();

  assign if0.din = din8;
  assign if1.din = din8;
  assign if2.din = din12;
  assign if0.clr = clr;
  assign if1.clr = clr;
  assign if2.clr = clr;

  key_encode_latch #(.N_KEYS(8),  .DEBOUNCE_CYCLES(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  key_encode_latch #(.N_KEYS(8),  .DEBOUNCE_CYCLES(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  key_encode_latch #(.N_KEYS(12), .DEBOUNCE_CYCLES(2), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int d, input int v);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_valid dut%0d: got strobe with value %0d at cycle %0d, expected none", d, v, cyc);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("strobe_value dut%0d", d), v, e.code);
      check($sformatf("strobe_cycle dut%0d", d), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) if (rst_n === 1'b1 && if0.valid) mon(0, int'(if0.value));
  always @(negedge clk) if (rst_n === 1'b1 && if1.valid) mon(1, int'(if1.value));
  always @(negedge clk) if (rst_n === 1'b1 && if2.valid) mon(2, int'(if2.value));

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; din8 = 8'hFF; din12 = 12'hFFF; clr = 1'b0;
    wt(3);
    din8 = '0; din12 = '0; rst_n = 1'b1;
    wt(4);
    check("rst_value0", int'(if0.value), 0);
    check("rst_err0",   int'(if0.err), 0);
    check("rst_held0",  int'(if0.held), 0);
    check("rst_seg0",   int'(if0.dout_digit), 'h3F);
    check("rst_value2", int'(if2.value), 0);

    // clean press, key 5 -> code 3
    din8 = 8'b0010_0000;
    push(0, 3, cyc + 6); push(1, 3, cyc + 6);
    wt(10);
    check("press_held0",  int'(if0.held), 1);
    check("press_value0", int'(if0.value), 3);
    check("press_seg0",   int'(if0.dout_digit), 'h4F);
    din8 = '0;
    wt(6);
    check("release_held0",  int'(if0.held), 0);
    check("release_value0", int'(if0.value), 3);

    // bounce, then stable key 4 -> code 4
    repeat (3) begin
      din8 = 8'h10; wt(2);
      din8 = 8'h00; wt(2);
    end
    din8 = 8'h10;
    push(0, 4, cyc + 6); push(1, 4, cyc + 6);
    wt(10);
    check("bounce_value0", int'(if0.value), 4);
    check("bounce_seg0",   int'(if0.dout_digit), 'h66);
    din8 = '0;
    wt(8);

    // multi-hot: strict flags error, priority takes bit 7 -> code 1
    din8 = 8'h81;
    push(1, 1, cyc + 6);
    wt(8);
    check("multi_err0",   int'(if0.err), 1);
    check("multi_value0", int'(if0.value), 4);
    check("multi_err1",   int'(if1.err), 0);
    check("multi_value1", int'(if1.value), 1);
    din8 = '0;
    wt(8);
    check("err_sticky0", int'(if0.err), 1);
    clr = 1'b1; wt(1); clr = 1'b0; wt(1);
    check("clr_err0",   int'(if0.err), 0);
    check("clr_value0", int'(if0.value), 0);
    check("clr_value1", int'(if1.value), 0);

    // key change mid-count: code 8 abandoned, code 7 latched
    din8 = 8'h01; wt(2);
    din8 = 8'h02;
    push(0, 7, cyc + 6); push(1, 7, cyc + 6);
    wt(10);
    check("change_value0", int'(if0.value), 7);
    din8 = '0;
    wt(8);

    // clr coinciding with the latch edge
    din8 = 8'h04;
    push(0, 6, cyc + 6); push(1, 6, cyc + 6);
    wt(5);
    clr = 1'b1; wt(1); clr = 1'b0;
    check("clr_latch_value0", int'(if0.value), 6);
    wt(1);
    check("clr_latch_after0", int'(if0.value), 6);
    din8 = '0;
    wt(8);

    // reset while counting: no strobe, everything zero
    din8 = 8'h08;
    wt(4);
    rst_n = 1'b0; din8 = '0;
    wt(2);
    rst_n = 1'b1;
    wt(8);
    check("midrst_value0", int'(if0.value), 0);
    check("midrst_held0",  int'(if0.held), 0);

    // 12 keys, 2-cycle debounce: bit 0 -> code 12
    din12 = 12'h001;
    push(2, 12, cyc + 4);
    wt(8);
    check("n12_value2", int'(if2.value), 12);
    check("n12_seg2",   int'(if2.dout_digit), 'h39);
    check("n12_held2",  int'(if2.held), 1);
    din12 = '0;
    wt(6);
    check("n12_release2", int'(if2.held), 0);

    check("pending_dut0", q0.size(), 0);
    check("pending_dut1", q1.size(), 0);
    check("pending_dut2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
